// File: rtl/cpu_mem_sequencer_if.sv
// CPU / SRAM / video bus bundle for cpu_mem_sequencer.
// master = the sequencer (drives PHI2, CPU data return, SRAM strobes, video ack).
// slave  = the surrounding system (CPU pins, SRAM data return, video requester).
interface cpu_mem_sequencer_if;
  // divider control and CPU clock
  logic        stop;
  logic        clk_cpu;
  // CPU bus
  logic        rw;
  logic        vpa;
  logic        vda;
  logic [15:0] addr;
  logic [7:0]  db_in;
  logic [7:0]  db_out;
  logic        db_oe;
  logic [7:0]  bank;
  // SRAM
  logic [23:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_doe;
  logic        ram_cs_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  // video read port
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;

  modport master (
    input  stop, rw, vpa, vda, addr, db_in, ram_din, vid_req, vid_addr,
    output clk_cpu, db_out, db_oe, bank, ram_addr, ram_dout, ram_doe,
           ram_cs_n, ram_oe_n, ram_we_n, vid_ack, vid_data
  );

  modport slave (
    output stop, rw, vpa, vda, addr, db_in, ram_din, vid_req, vid_addr,
    input  clk_cpu, db_out, db_oe, bank, ram_addr, ram_dout, ram_doe,
           ram_cs_n, ram_oe_n, ram_we_n, vid_ack, vid_data
  );
endinterface

// File: rtl/cpu_mem_sequencer.sv
// W65C816 memory sequencer: derives PHI2 from the system clock, latches the
// bank byte, runs one SRAM access per CPU high phase and squeezes a bounded
// number of single-cycle video reads into each low phase.
// All strobes are registered: the next-state logic decides the access and the
// FSM register block computes every output from (next state, next count), so
// outputs change exactly on the cycle the counter reaches the relevant value
// and freeze together with the counter when stop is asserted.
module cpu_mem_sequencer #(
  parameter int CLKDIV  = 3,
  parameter int VID_MAX = 2
) (
  input logic                 clk_50mhz,
  input logic                 rst_n,
  cpu_mem_sequencer_if.master bus
);

  localparam int CW = CLKDIV + 1;
  localparam int H  = 1 << CLKDIV;

  // counter landmarks within one clk_cpu period
  localparam logic [CW-1:0] C_HM3  = CW'(H - 3);     // latest video issue point
  localparam logic [CW-1:0] C_HM1  = CW'(H - 1);     // last low-phase cycle
  localparam logic [CW-1:0] C_H    = CW'(H);         // first high-phase cycle
  localparam logic [CW-1:0] C_HP1  = CW'(H + 1);     // write strobe start
  localparam logic [CW-1:0] C_2HM2 = CW'(2 * H - 2); // write strobe end
  localparam logic [CW-1:0] C_2HM1 = CW'(2 * H - 1); // last high-phase cycle
  localparam logic [CW-1:0] C_VMAX = CW'(VID_MAX);

  typedef enum logic [2:0] {
    IDLE,
    VID_A,
    VID_D,
    CPU_RD,
    CPU_WR
  } state_t;

  // divider and bank latch
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_bank;

  // FSM and registered outputs
  state_t        r_state;
  logic [CW-1:0] r_grants;
  logic [23:0]   r_ram_addr;
  logic          r_cs_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic          r_ram_doe;
  logic [7:0]    r_ram_dout;
  logic          r_db_oe;
  logic [7:0]    r_db_out;
  logic          r_vid_ack;
  logic [7:0]    r_vid_data;

  // next-state terms
  logic [CW-1:0] w_cnt_next;
  logic          w_low_end;
  logic          w_wrap;
  logic          w_valid;
  logic          w_vid_go;
  logic          w_cpu_next;
  logic          w_cpu_now;
  state_t        w_state_next;

  // Counter advance plus the phase events that only count while the divider runs.
  always_comb begin
    w_cnt_next = bus.stop ? r_cnt : r_cnt + 1'b1;
    w_low_end  = (r_cnt == C_HM1) && !bus.stop;
    w_wrap     = (r_cnt == C_2HM1) && !bus.stop;
    w_valid    = bus.vpa | bus.vda;
    // C_HM3 is below H, so this also keeps video out of the high phase
    w_vid_go   = bus.vid_req && (r_grants < C_VMAX) && (r_cnt <= C_HM3);
  end

  // Next-state decision: CPU access is claimed on the edge into the high phase.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_low_end) begin
          if (w_valid) w_state_next = bus.rw ? CPU_RD : CPU_WR;
        end else if (w_vid_go) begin
          w_state_next = VID_A;
        end
      end
      VID_A: w_state_next = VID_D;
      // a video read issued at H-3 finishes on H-1, so VID_D may hand over to the CPU
      VID_D: begin
        w_state_next = IDLE;
        if (w_low_end && w_valid) w_state_next = bus.rw ? CPU_RD : CPU_WR;
      end
      CPU_RD, CPU_WR: begin
        if (w_wrap) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    w_cpu_next = (w_state_next == CPU_RD) || (w_state_next == CPU_WR);
    w_cpu_now  = (r_state == CPU_RD) || (r_state == CPU_WR);
  end

  // Divider counter and bank byte capture on the last low-phase cycle.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_bank <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_low_end) r_bank <= bus.db_in;
    end
  end

  // Sequencer FSM with all SRAM / CPU / video outputs registered from next state.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grants   <= '0;
      r_ram_addr <= '0;
      r_cs_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_ram_doe  <= 1'b0;
      r_ram_dout <= '0;
      r_db_oe    <= 1'b0;
      r_db_out   <= '0;
      r_vid_ack  <= 1'b0;
      r_vid_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ram_dout <= bus.db_in;
      r_vid_ack  <= 1'b0;

      // grant budget renews as the new low phase starts
      if (w_wrap) begin
        r_grants <= '0;
      end else if ((r_state == IDLE) && (w_state_next == VID_A)) begin
        r_grants <= r_grants + 1'b1;
      end

      // CPU read data follows SRAM one cycle behind the address
      if (r_state == CPU_RD) r_db_out <= bus.ram_din;

      // the single video SRAM cycle is VID_A; its data is returned with the ack
      if (r_state == VID_A) begin
        r_vid_data <= bus.ram_din;
        r_vid_ack  <= 1'b1;
      end

      // address is loaded only when an access starts and otherwise holds;
      // db_in is the same byte the bank latch takes on this edge
      if (w_cpu_next && !w_cpu_now) begin
        r_ram_addr <= {bus.db_in, bus.addr};
      end else if ((w_state_next == VID_A) && (r_state != VID_A)) begin
        r_ram_addr <= bus.vid_addr;
      end

      r_cs_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_ram_doe <= 1'b0;
      r_db_oe   <= 1'b0;
      case (w_state_next)
        VID_A: begin
          r_cs_n <= 1'b0;
          r_oe_n <= 1'b0;
        end
        CPU_RD: begin
          r_cs_n  <= 1'b0;
          r_oe_n  <= 1'b0;
          // CPU drive starts one cycle after the address so db_out is valid
          r_db_oe <= (w_cnt_next != C_H);
        end
        CPU_WR: begin
          r_cs_n    <= 1'b0;
          r_ram_doe <= 1'b1;
          // strobe is inset one cycle at both ends of the high phase for
          // address/data setup and hold; a frozen count freezes the strobe
          r_we_n    <= !((w_cnt_next >= C_HP1) && (w_cnt_next <= C_2HM2));
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.clk_cpu  = r_cnt[CW-1];
  assign bus.bank     = r_bank;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_cs_n = r_cs_n;
  assign bus.ram_oe_n = r_oe_n;
  assign bus.ram_we_n = r_we_n;
  assign bus.ram_doe  = r_ram_doe;
  assign bus.ram_dout = r_ram_dout;
  assign bus.db_oe    = r_db_oe;
  assign bus.db_out   = r_db_out;
  assign bus.vid_ack  = r_vid_ack;
  assign bus.vid_data = r_vid_data;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed bench for cpu_mem_sequencer at CLKDIV=3 (16-cycle PHI2), VID_MAX=2.
// A bench-side phase counter tracks where the divider should be; SRAM is a
// combinational model returning 0xA5 at 0x012000 and (addr[7:0]^0x5A) elsewhere.
module tb_cpu_mem_sequencer;

  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_cnt   = '0;
  int         we_falls = 0;
  logic       prev_we  = 1'b1;

  cpu_mem_sequencer_if bus();

  cpu_mem_sequencer #(
    .CLKDIV  (3),
    .VID_MAX (2)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  assign bus.ram_din = (bus.ram_addr == 24'h012000) ? 8'hA5 : (bus.ram_addr[7:0] ^ 8'h5A);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // one clock; sample 1 time unit after the edge; track expected count and we_n falls
  task automatic step();
    logic s;
    s = bus.stop;
    @(posedge clk_50mhz);
    #1;
    if (!rst_n) m_cnt = '0;
    else if (!s) m_cnt = m_cnt + 4'd1;
    if (prev_we && !bus.ram_we_n) we_falls++;
    prev_we = bus.ram_we_n;
  endtask

  task automatic goto_cnt(input logic [3:0] c);
    for (int i = 0; i < 40 && m_cnt != c; i++) step();
    check($sformatf("phase_at_%0d", c), {31'd0, bus.clk_cpu}, {31'd0, c[3]});
  endtask

  initial begin
    int hi, rises, acks, first_ack, last_ack, high_acks, viol;
    logic prev_clk;

    bus.stop     = 1'b0;
    bus.rw       = 1'b1;
    bus.vpa      = 1'b0;
    bus.vda      = 1'b0;
    bus.addr     = 16'h0000;
    bus.db_in    = 8'h00;
    bus.vid_req  = 1'b0;
    bus.vid_addr = 24'h000033;

    // ---- reset state
    repeat (3) step();
    check("rst_clk_cpu", {31'd0, bus.clk_cpu}, 32'd0);
    check("rst_bank", {24'd0, bus.bank}, 32'd0);
    check("rst_strobes", {29'd0, bus.ram_cs_n, bus.ram_oe_n, bus.ram_we_n}, 32'h7);
    check("rst_oe", {30'd0, bus.ram_doe, bus.db_oe}, 32'd0);
    check("rst_vid", {23'd0, bus.vid_ack, bus.vid_data}, 32'd0);
    check("rst_ram_addr", {8'd0, bus.ram_addr}, 32'd0);
    $display("reset: clk_cpu=%0d strobes=%b%b%b", bus.clk_cpu, bus.ram_cs_n, bus.ram_oe_n, bus.ram_we_n);

    // ---- first rise H cycles after release
    rst_n = 1'b1;
    repeat (7) step();
    check("first_rise_cnt7", {31'd0, bus.clk_cpu}, 32'd0);
    step();
    check("first_rise_cnt8", {31'd0, bus.clk_cpu}, 32'd1);
    $display("release: clk_cpu rose after 8 cycles");

    // ---- period and duty
    goto_cnt(4'd0);
    hi = 0;
    rises = 0;
    prev_clk = bus.clk_cpu;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.clk_cpu) hi++;
      if (!prev_clk && bus.clk_cpu) rises++;
      prev_clk = bus.clk_cpu;
    end
    check("duty_high_cycles", hi, 32'd8);
    check("rises_per_16", rises, 32'd1);
    $display("divider: high=%0d rises=%0d per 16 cycles", hi, rises);

    // ---- bank latch, no access
    goto_cnt(4'd7);
    bus.db_in = 8'h12;
    step();
    check("bank_latch", {24'd0, bus.bank}, 32'h12);
    check("no_access_cs", {31'd0, bus.ram_cs_n}, 32'd1);
    bus.db_in = 8'h77;
    step();
    check("bank_hold", {24'd0, bus.bank}, 32'h12);
    bus.db_in = 8'h00;
    $display("bank: latched 0x%02h", bus.bank);

    // ---- CPU read
    goto_cnt(4'd7);
    bus.db_in = 8'h01;
    bus.vpa   = 1'b1;
    bus.rw    = 1'b1;
    bus.addr  = 16'h2000;
    step();
    check("rd_addr", {8'd0, bus.ram_addr}, 32'h012000);
    check("rd_c8", {29'd0, bus.ram_cs_n, bus.ram_oe_n, bus.db_oe}, 32'd0);
    bus.vpa   = 1'b0;
    bus.db_in = 8'h00;
    for (int i = 9; i <= 15; i++) begin
      step();
      check($sformatf("rd_c%0d", i), {22'd0, bus.ram_oe_n, bus.db_oe, bus.db_out}, {22'd0, 1'b0, 1'b1, 8'hA5});
    end
    step();
    check("rd_end", {29'd0, bus.ram_cs_n, bus.ram_oe_n, bus.db_oe}, 32'h6);
    $display("cpu read: addr=0x012000 data=0x%02h", bus.db_out);

    // ---- CPU write
    goto_cnt(4'd7);
    bus.db_in = 8'h01;
    bus.vda   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 16'h2100;
    we_falls  = 0;
    step();
    check("wr_c8", {29'd0, bus.ram_we_n, bus.ram_oe_n, bus.ram_doe}, 32'h7);
    bus.db_in = 8'h3C;
    bus.vda   = 1'b0;
    for (int i = 9; i <= 15; i++) begin
      step();
      check($sformatf("wr_c%0d", i), {21'd0, bus.ram_we_n, bus.ram_oe_n, bus.ram_doe, bus.ram_dout},
            {21'd0, (i <= 14) ? 1'b0 : 1'b1, 1'b1, 1'b1, 8'h3C});
    end
    step();
    check("wr_end", {29'd0, bus.ram_we_n, bus.ram_doe, bus.ram_cs_n}, 32'h5);
    check("wr_pulses", we_falls, 32'd1);
    bus.rw    = 1'b1;
    bus.db_in = 8'h00;
    $display("cpu write: addr=0x012100 data=0x3C pulses=%0d", we_falls);

    // ---- video: request held through a whole phase
    goto_cnt(4'd15);
    bus.vid_req = 1'b1;
    acks = 0;
    first_ack = -1;
    last_ack = -1;
    high_acks = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (m_cnt == 4'd1) begin
        check("vid_strobe", {30'd0, bus.ram_cs_n, bus.ram_oe_n}, 32'd0);
        check("vid_addr", {8'd0, bus.ram_addr}, 32'h000033);
      end
      if (bus.vid_ack) begin
        acks++;
        if (first_ack < 0) first_ack = int'(m_cnt);
        last_ack = int'(m_cnt);
        if (m_cnt >= 4'd8) high_acks++;
        check("vid_data", {24'd0, bus.vid_data}, 32'h69);
      end
      if (m_cnt == 4'd15) bus.vid_req = 1'b0;
    end
    check("vid_ack_count", acks, 32'd2);
    check("vid_first_ack", first_ack, 32'd2);
    check("vid_last_ack", last_ack, 32'd5);
    check("vid_high_acks", high_acks, 32'd0);
    $display("video: acks=%0d first=%0d last=%0d", acks, first_ack, last_ack);

    // ---- video: late request waits for next low phase
    goto_cnt(4'd6);
    bus.vid_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.vid_ack) acks++;
    end
    check("late_no_ack", acks, 32'd0);
    step();
    step();
    step();
    check("late_ack_c2", {31'd0, bus.vid_ack}, 32'd1);
    bus.vid_req = 1'b0;
    step();
    check("late_ack_one", {31'd0, bus.vid_ack}, 32'd0);
    $display("video late: served at next-phase cnt=2");

    // ---- stop during write
    goto_cnt(4'd7);
    bus.db_in = 8'h01;
    bus.vda   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 16'h2200;
    we_falls  = 0;
    step();
    bus.db_in = 8'h3C;
    bus.vda   = 1'b0;
    goto_cnt(4'd10);
    check("stop_we_c10", {31'd0, bus.ram_we_n}, 32'd0);
    bus.stop = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!bus.clk_cpu || bus.ram_we_n) viol++;
    end
    check("stop_frozen", viol, 32'd0);
    bus.stop = 1'b0;
    goto_cnt(4'd14);
    check("stop_we_c14", {31'd0, bus.ram_we_n}, 32'd0);
    step();
    check("stop_we_c15", {31'd0, bus.ram_we_n}, 32'd1);
    goto_cnt(4'd0);
    check("stop_pulses", we_falls, 32'd1);
    bus.rw    = 1'b1;
    bus.db_in = 8'h00;
    $display("stop write: pulses=%0d", we_falls);

    // ---- reset in the middle of a write
    goto_cnt(4'd7);
    bus.db_in = 8'h01;
    bus.vda   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 16'h2300;
    step();
    bus.db_in = 8'h3C;
    bus.vda   = 1'b0;
    goto_cnt(4'd12);
    check("rst_mid_we_before", {31'd0, bus.ram_we_n}, 32'd0);
    rst_n = 1'b0;
    m_cnt = '0;
    #2;
    check("rst_mid_we", {31'd0, bus.ram_we_n}, 32'd1);
    check("rst_mid_oe", {30'd0, bus.ram_doe, bus.db_oe}, 32'd0);
    check("rst_mid_cs", {31'd0, bus.ram_cs_n}, 32'd1);
    check("rst_mid_clk", {31'd0, bus.clk_cpu}, 32'd0);
    check("rst_mid_bank", {24'd0, bus.bank}, 32'd0);
    check("rst_mid_addr", {8'd0, bus.ram_addr}, 32'd0);
    $display("reset mid-write: we_n=%0d db_oe=%0d", bus.ram_we_n, bus.db_oe);
    repeat (2) step();
    check("rst_hold_we", {31'd0, bus.ram_we_n}, 32'd1);
    bus.rw = 1'b1;
    rst_n = 1'b1;
    repeat (8) step();
    check("rerelease_rise", {31'd0, bus.clk_cpu}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_sequencer.md
CPU_MEM_SEQUENCER -- requirements
Module: cpu_mem_sequencer

Interface
REQ-001 SHALL have parameter CLKDIV, default 3, clk_cpu divide exponent (clk_cpu = clk_50mhz / 2^(CLKDIV+1)), legal range 2..6.
REQ-002 SHALL have parameter VID_MAX, default 2, maximum video reads granted per clk_cpu low phase, legal range 0..(2^CLKDIV-1)/2.
REQ-003 clk_50mhz  in  1  system clock; all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 stop  in  1  1 = freeze clk_cpu divider.
REQ-006 clk_cpu  out  1  W65C816 PHI2.
REQ-007 rw, vpa, vda  in  1 each  CPU bus status.
REQ-008 addr  in  16  CPU address.
REQ-009 db_in  in  8  CPU data/bank bus, input side.
REQ-010 db_out  out  8; db_oe  out  1  CPU bus drive toward CPU.
REQ-011 bank  out  8  latched bank byte.
REQ-012 ram_addr  out  24; ram_dout  out  8; ram_din  in  8; ram_doe  out  1  SRAM address/data.
REQ-013 ram_cs_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
REQ-014 vid_req  in  1; vid_addr  in  24  video read request, held until acked.
REQ-015 vid_ack  out  1; vid_data  out  8  one-cycle ack, data valid with ack.

Function
REQ-016 Divider: counter cnt of CLKDIV+1 bits increments each cycle when stop=0, wraps; clk_cpu = cnt MSB; H = 2^CLKDIV cycles per half phase.
REQ-017 stop=1 holds cnt and clk_cpu; all other logic keeps running.
REQ-018 Bank latch: bank <= db_in on the cycle cnt = H-1 with stop=0 (last low-phase cycle); bank holds otherwise.
REQ-019 valid = vpa | vda, sampled at first high-phase cycle (cnt = H) together with rw and {bank,addr}; held for the phase.
REQ-020 FSM states: IDLE, VID_A, VID_D, CPU_RD, CPU_WR.
REQ-021 IDLE -> CPU_RD / CPU_WR at cnt = H when valid, per rw; IDLE stays when not valid (no RAM strobe that phase).
REQ-022 CPU_RD: ram_addr = latched {bank,addr}, ram_cs_n=0, ram_oe_n=0 whole high phase; db_out = ram_din, db_oe=1 from cnt = H+1 through cnt = 2H-1.
REQ-023 CPU_WR: ram_dout = db_in registered each cycle, ram_doe=1 whole phase; ram_we_n=0 only for cnt in H+1..2H-2; ram_oe_n=1.
REQ-024 CPU_RD/CPU_WR -> IDLE on cycle cnt wraps to 0; db_oe=0 and ram_we_n=1 on that cycle.
REQ-025 Video: in low phase, IDLE -> VID_A when vid_req=1, grants this phase < VID_MAX, and cnt <= H-3; VID_A drives ram_addr=vid_addr, cs_n=0, oe_n=0.
REQ-026 VID_A -> VID_D next cycle; VID_D captures ram_din to vid_data, pulses vid_ack=1 one cycle, returns to IDLE.
REQ-027 Grant counter clears at cnt = 0; vid_req arriving too late (cnt > H-3) waits for next low phase.
REQ-028 CPU access always wins: video never issued in high phase; a video read never overlaps cnt = H.
REQ-029 stop=1 mid-phase: current state and strobes hold; CPU_WR we_n pulse is frozen, not repeated; video reads may still complete but grant count still limits.
REQ-030 Idle outputs: cs_n=oe_n=we_n=1, ram_doe=0, db_oe=0, ram_addr holds last value.

Reset
REQ-031 rst_n=0 asynchronously: cnt=0, clk_cpu=0, bank=0, FSM=IDLE, grants=0, vid_ack=0, vid_data=0, db_oe=0, ram_doe=0, strobes=1, ram_addr=0.
REQ-032 After rst_n release first clk_cpu rise occurs H cycles later; reset mid-access aborts it without a we_n glitch.

Verification
REQ-033 CLKDIV=3, free run -> clk_cpu period 16 cycles, 50% duty; db_in=0x12 at cnt=7 -> bank=0x12.
REQ-034 CPU read vpa=1, bank 0x01, addr 0x2000, ram_din=0xA5 -> ram_addr=0x012000, oe_n low cnt 8..15, db_out=0xA5 with db_oe cnt 9..15.
REQ-035 CPU write rw=0, db_in=0x3C -> we_n low exactly cnt 9..14, ram_dout=0x3C, oe_n=1.
REQ-036 vid_req held all low phase, VID_MAX=2 -> exactly 2 vid_acks, last before cnt=7; none in high phase; vid_req at cnt=6 -> served next phase.
REQ-037 stop=1 at cnt=10 during write for 20 cycles -> clk_cpu stays 1, we_n stays low, single pulse total after release.
REQ-038 rst_n low at cnt=12 during write -> we_n=1, db_oe=0 immediately; all REQ-031 values.
